// File: rtl/hazard_scoreboard_pkg.sv
// hazard_pkg: shared types and defaults for the hazard scoreboard
// Contents: fwd_sel_e forward selects, op_class_e D-stage op classes, REG_AW_DEF register address width
package hazard_pkg;
    localparam int REG_AW_DEF = 5;
    typedef enum logic [1:0] {FWD_RF = 2'b00, FWD_W = 2'b01, FWD_M = 2'b10} fwd_sel_e;
    typedef enum logic [1:0] {CLS_ALU = 2'd0, CLS_LOAD = 2'd1, CLS_MC = 2'd2} op_class_e;
endpackage

// File: rtl/hazard_scoreboard_if.sv
// hazard_if: pipeline <-> hazard unit signal bundle
// master: pipeline side (drives stage register fields, receives stall/flush/forward/MC status)
// slave:  hazard unit side (the reverse)
interface hazard_if #(
    parameter int REG_AW  = hazard_pkg::REG_AW_DEF,
    parameter int NUM_SRC = 2,
    parameter int CNT_W   = 16
);
    logic [NUM_SRC*REG_AW-1:0] rs_d;
    logic [REG_AW-1:0]         rd_d;
    logic                      regwrite_d;
    logic [1:0]                class_d;
    logic [NUM_SRC*REG_AW-1:0] rs_e;
    logic [REG_AW-1:0]         rd_e;
    logic                      regwrite_e;
    logic                      resultsrc_e;
    logic [REG_AW-1:0]         rd_m;
    logic [REG_AW-1:0]         rd_w;
    logic                      regwrite_m;
    logic                      regwrite_w;
    logic                      pcsrc_e;
    logic                      stall_f;
    logic                      stall_d;
    logic                      flush_d;
    logic                      flush_e;
    logic [NUM_SRC*2-1:0]      fwd_e;
    logic                      mc_busy;
    logic                      mc_wb;
    logic [REG_AW-1:0]         mc_rd;
    logic [CNT_W-1:0]          stall_cnt;
    modport master (
        output rs_d, rd_d, regwrite_d, class_d, rs_e, rd_e, regwrite_e, resultsrc_e,
               rd_m, rd_w, regwrite_m, regwrite_w, pcsrc_e,
        input  stall_f, stall_d, flush_d, flush_e, fwd_e, mc_busy, mc_wb, mc_rd, stall_cnt
    );
    modport slave (
        input  rs_d, rd_d, regwrite_d, class_d, rs_e, rd_e, regwrite_e, resultsrc_e,
               rd_m, rd_w, regwrite_m, regwrite_w, pcsrc_e,
        output stall_f, stall_d, flush_d, flush_e, fwd_e, mc_busy, mc_wb, mc_rd, stall_cnt
    );
endinterface

// File: rtl/hazard_scoreboard_mc_tracker.sv
// mc_tracker: one-entry scoreboard for the fixed-latency multicycle unit
// Ports: clk, rst (async high), alloc/alloc_rd (issue of an MC op), busy, rd (outstanding dest), wb (result written this cycle)
module mc_tracker #(
    parameter int REG_AW = hazard_pkg::REG_AW_DEF,
    parameter int MC_LAT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alloc,
    input  logic [REG_AW-1:0] alloc_rd,
    output logic              busy,
    output logic [REG_AW-1:0] rd,
    output logic              wb
);
    localparam int CW = $clog2(MC_LAT + 1);
    logic [CW-1:0] cnt;
    assign wb = busy && cnt == CW'(1);
    // Allocation wins over the clear so a new op can start in the write-back cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            rd   <= '0;
            cnt  <= '0;
        end else if (alloc) begin
            busy <= 1'b1;
            rd   <= alloc_rd;
            cnt  <= CW'(MC_LAT);
        end else if (busy) begin
            cnt  <= cnt - 1'b1;
            busy <= !wb;
        end
    end
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: forwarding, load-use/MC stalls, branch flush and stall counter for a 5-stage pipeline
// Ports: clk, rst (async high), hz (hazard_if.slave carrying all stage fields and hazard outputs)
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_AW  = REG_AW_DEF,
    parameter int NUM_SRC = 2,
    parameter int MC_LAT  = 4,
    parameter int CNT_W   = 16
) (
    input logic     clk,
    input logic     rst,
    hazard_if.slave hz
);
    logic [NUM_SRC*2-1:0] fwd;
    logic                 load_use;
    logic                 mc_raw;
    logic                 hazard;
    logic                 stall;
    logic                 alloc;
    logic                 busy;
    logic                 wb;
    logic [REG_AW-1:0]    mc_rd;
    logic [CNT_W-1:0]     cnt;
    always_comb begin
        fwd      = '0;
        load_use = 1'b0;
        mc_raw   = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            fwd[2*i +: 2] = (hz.regwrite_m && hz.rd_m != '0 && hz.rd_m == hz.rs_e[i*REG_AW +: REG_AW]) ? FWD_M :
                            (hz.regwrite_w && hz.rd_w != '0 && hz.rd_w == hz.rs_e[i*REG_AW +: REG_AW]) ? FWD_W : FWD_RF;
            load_use = load_use || (hz.resultsrc_e && hz.regwrite_e && hz.rd_e != '0 &&
                                    hz.rd_e == hz.rs_d[i*REG_AW +: REG_AW]);
            mc_raw   = mc_raw || (busy && mc_rd == hz.rs_d[i*REG_AW +: REG_AW]);
        end
    end
    // Data hazards on the MC result hold through the write-back cycle (no MC forwarding);
    // the structural hazard releases in that cycle so a new MC op can allocate back-to-back.
    assign hazard = load_use || mc_raw || (busy && hz.regwrite_d && hz.rd_d == mc_rd) ||
                    (busy && !wb && hz.class_d == CLS_MC);
    assign stall  = hazard && !hz.pcsrc_e;
    assign alloc  = !stall && !hz.pcsrc_e && hz.class_d == CLS_MC && hz.regwrite_d && hz.rd_d != '0;
    mc_tracker #(.REG_AW(REG_AW), .MC_LAT(MC_LAT)) u_mc (
        .clk      (clk),
        .rst      (rst),
        .alloc    (alloc),
        .alloc_rd (hz.rd_d),
        .busy     (busy),
        .rd       (mc_rd),
        .wb       (wb)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt <= '0;
        else if (stall && cnt != '1) cnt <= cnt + 1'b1;
    end
    // Combinational outputs are forced low while reset is held so everything reads 0 at once.
    assign hz.stall_f   = !rst && stall;
    assign hz.stall_d   = !rst && stall;
    assign hz.flush_d   = !rst && hz.pcsrc_e;
    assign hz.flush_e   = !rst && (hz.pcsrc_e || hazard);
    assign hz.fwd_e     = rst ? '0 : fwd;
    assign hz.mc_busy   = busy;
    assign hz.mc_wb     = wb;
    assign hz.mc_rd     = mc_rd;
    assign hz.stall_cnt = cnt;
endmodule
